// File: rtl/magma_round_ctrl.sv
// magma_round_ctrl: sequences 32 Magma Feistel rounds through an external g[k] round unit
module magma_round_ctrl #(
  parameter int NUM_ROUNDS = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         mode,
  input  logic [63:0]  data_in,
  input  logic [255:0] key_in,
  output logic         rnd_valid,
  input  logic         rnd_ready,
  output logic [31:0]  rnd_a,
  output logic [31:0]  rnd_k,
  input  logic         rnd_res_valid,
  input  logic [31:0]  rnd_res,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [63:0]  data_out
);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t         state, state_nx;
  logic [4:0]     round;
  logic [31:0]    a1, a0, t;
  logic [255:0]   key;
  logic           mode_q, last, timeout, rev;
  logic [2:0]     pos;
  logic [TW-1:0]  cnt;
  assign t       = a1 ^ rnd_res;
  assign last    = round == 5'(NUM_ROUNDS - 1);
  assign timeout = TIMEOUT != 0 && cnt == TW'(TIMEOUT - 1);
  assign rev     = mode_q ? round >= 5'd8 : round >= 5'd24;
  assign pos     = rev ? round[2:0] : ~round[2:0];
  assign rnd_a   = a0;
  assign rnd_k   = key[{pos, 5'd0} +: 32];
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  // next state and status outputs
  always_comb begin
    state_nx  = state;
    rnd_valid = state == ISSUE;
    busy      = state == ISSUE || state == WAIT;
    done      = state == DONE;
    case (state)
      IDLE:    state_nx = start ? ISSUE : IDLE;
      ISSUE:   state_nx = rnd_ready ? WAIT : ISSUE;
      WAIT:    state_nx = rnd_res_valid ? (last ? DONE : ISSUE) : (timeout ? IDLE : WAIT);
      default: state_nx = IDLE;
    endcase
  end
  // block halves, key, round counter, timeout counter and result
  always_ff @(posedge clk) begin
    if (reset) begin
      round    <= '0;
      a1       <= '0;
      a0       <= '0;
      key      <= '0;
      mode_q   <= 1'b0;
      cnt      <= '0;
      data_out <= '0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      if (state == IDLE && start) begin
        a1     <= data_in[63:32];
        a0     <= data_in[31:0];
        key    <= key_in;
        mode_q <= mode;
        round  <= '0;
      end else if (state == ISSUE && rnd_ready) begin
        cnt <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + TW'(1);
        if (rnd_res_valid && last) begin
          data_out <= {t, a0};
        end else if (rnd_res_valid) begin
          a1    <= a0;
          a0    <= t;
          round <= round + 5'd1;
        end else if (timeout) begin
          err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_magma_round_ctrl.sv
// tb_magma_round_ctrl: vector table plus random blocks against a Magma reference model
module tb_magma_round_ctrl;
  logic         clk = 1'b0, reset, start, mode, rnd_valid, rnd_ready, rnd_res_valid, busy, done, err;
  logic [63:0]  data_in, data_out;
  logic [255:0] key_in;
  logic [31:0]  rnd_a, rnd_k, rnd_res;
  int n_vec = 0, n_bad = 0;
  int ready_pct = 100, lat_max = 1, wait_n = 0, hs = 0, stab_bad = 0;
  bit respond = 1, pend = 0, stall = 0, stray = 0;
  logic [31:0] pa, pk, sa, sk;
  logic [31:0] kq[$];
  localparam logic [255:0] KEY = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [63:0]  PT  = 64'hfedcba9876543210;
  localparam logic [63:0]  CT  = 64'h4ee901e5c2d8ca3d;
  typedef struct {
    bit           mode;
    logic [63:0]  data;
    logic [255:0] key;
    logic [63:0]  exp;
    int           rp;
    int           lm;
  } vec_t;
  vec_t v[9];
  magma_round_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .data_in(data_in), .key_in(key_in),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_a(rnd_a), .rnd_k(rnd_k),
    .rnd_res_valid(rnd_res_valid), .rnd_res(rnd_res), .busy(busy), .done(done), .err(err),
    .data_out(data_out)
  );
  always #5 clk = ~clk;
  function automatic logic [3:0] pi(int i, logic [3:0] x);
    logic [63:0] row;
    case (i)
      0: row = 64'hC462A5B9E8D703F1;
      1: row = 64'h68239A5C1E47BD0F;
      2: row = 64'hB3582FADE174C960;
      3: row = 64'hC821D4F670A53E9B;
      4: row = 64'h7F5A816D093EB42C;
      5: row = 64'h5DF692CAB78143E0;
      6: row = 64'h8E25691CF4B0DA37;
      default: row = 64'h17ED05834FA69CB2;
    endcase
    return row[60 - 4 * int'(x) +: 4];
  endfunction
  function automatic logic [31:0] g(logic [31:0] a, logic [31:0] k);
    logic [31:0] s, y;
    s = a + k;
    for (int i = 0; i < 8; i++) y[4*i +: 4] = pi(i, s[4*i +: 4]);
    return {y[20:0], y[31:21]};
  endfunction
  function automatic int kidx(bit m, int r);
    if (m) return r < 8 ? r : 7 - (r % 8);
    return r < 24 ? r % 8 : 7 - (r % 8);
  endfunction
  function automatic logic [31:0] subkey(logic [255:0] k, int i);
    return k[255 - 32*i -: 32];
  endfunction
  function automatic logic [63:0] magma(bit m, logic [63:0] d, logic [255:0] k);
    logic [31:0] x1, x0, t;
    logic [63:0] o;
    x1 = d[63:32];
    x0 = d[31:0];
    o = '0;
    for (int r = 0; r < 32; r++) begin
      t = x1 ^ g(x0, subkey(k, kidx(m, r)));
      if (r == 31) o = {t, x0};
      else begin
        x1 = x0;
        x0 = t;
      end
    end
    return o;
  endfunction
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // round unit model: random ready, 1..lat_max cycle latency, stability monitor
  initial begin
    rnd_ready = 1'b0;
    rnd_res_valid = 1'b0;
    rnd_res = '0;
    forever begin
      @(negedge clk);
      if (stall && rnd_valid && (rnd_a !== sa || rnd_k !== sk)) stab_bad++;
      rnd_res_valid = 1'b0;
      if (reset) pend = 0;
      else if (stray) begin
        rnd_res_valid = 1'b1;
        rnd_res = $urandom;
        stray = 0;
      end else if (pend) begin
        if (wait_n == 0) begin
          rnd_res_valid = 1'b1;
          rnd_res = g(pa, pk);
          pend = 0;
        end else wait_n--;
      end
      rnd_ready = $urandom_range(99) < ready_pct;
      if (rnd_valid && rnd_ready && !reset && !pend) begin
        pa = rnd_a;
        pk = rnd_k;
        kq.push_back(rnd_k);
        pend = respond;
        wait_n = $urandom_range(lat_max - 1, 0);
        hs++;
      end
      stall = rnd_valid && !rnd_ready && !reset;
      sa = rnd_a;
      sk = rnd_k;
    end
  end
  task automatic run(input bit m, input logic [63:0] d, input logic [255:0] k, input bit poke,
                     output logic [63:0] res, output int cyc);
    kq.delete();
    @(negedge clk);
    start = 1'b1;
    mode = m;
    data_in = d;
    key_in = k;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 3000) begin
      if (poke && cyc == 40) begin
        start = 1'b1;
        mode = ~m;
        data_in = ~d;
        key_in = ~k;
      end else start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    res = data_out;
    chk("done_seen", done, 1'b1);
  endtask
  initial begin
    logic [63:0] res, prev;
    int cyc, m, c;
    reset = 1'b1;
    start = 1'b0;
    mode = 1'b0;
    data_in = '0;
    key_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {rnd_valid, busy, done, err}, 4'b0);
    chk("rst_data_out", data_out, 0);
    chk("rst_rnd_a_k", {rnd_a, rnd_k}, 0);
    reset = 1'b0;
    v[0] = '{mode: 0, data: PT, key: KEY, exp: CT, rp: 100, lm: 1};
    v[1] = '{mode: 1, data: CT, key: KEY, exp: PT, rp: 100, lm: 1};
    v[2] = '{mode: 0, data: PT, key: KEY, exp: CT, rp: 60, lm: 5};
    for (int i = 3; i < 9; i++) begin
      v[i].mode = 1'($urandom_range(1));
      v[i].data = {$urandom, $urandom};
      for (int j = 0; j < 8; j++) v[i].key[32*j +: 32] = $urandom;
      v[i].exp = magma(v[i].mode, v[i].data, v[i].key);
      v[i].rp = $urandom_range(100, 30);
      v[i].lm = $urandom_range(5, 1);
    end
    for (int i = 0; i < 9; i++) begin
      ready_pct = v[i].rp;
      lat_max = v[i].lm;
      run(v[i].mode, v[i].data, v[i].key, i == 2 || i == 5, res, cyc);
      chk($sformatf("v%0d data_out", i), res, v[i].exp);
      m = kq.size() == 32 ? 0 : 99;
      for (int r = 0; r < 32 && m != 99; r++) if (kq[r] !== subkey(v[i].key, kidx(v[i].mode, r))) m++;
      chk($sformatf("v%0d subkey_order", i), m, 0);
      if (i == 0) chk("latency", cyc, 32 * 2 + 1);
      if (i == 1) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done", {busy, done}, 2'b00);
      end
      @(negedge clk);
    end
    chk("rnd_stable_under_stall", stab_bad, 0);
    prev = data_out;
    respond = 0;
    ready_pct = 100;
    @(negedge clk);
    start = 1'b1;
    mode = 1'b0;
    data_in = PT;
    key_in = KEY;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    while (!err && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("timeout_cycles", c, 10);
    chk("timeout_busy", busy, 1'b0);
    chk("timeout_data_out", data_out, prev);
    @(negedge clk);
    chk("err_pulse", err, 1'b0);
    respond = 1;
    lat_max = 1;
    hs = 0;
    @(negedge clk);
    start = 1'b1;
    mode = 1'b0;
    data_in = PT;
    key_in = KEY;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (hs < 18 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("reached_round17", hs >= 18, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_ctl", {rnd_valid, busy, done, err}, 4'b0);
    chk("midrst_data", {data_out, rnd_a, rnd_k}, 0);
    reset = 1'b0;
    stray = 1;
    repeat (3) @(negedge clk);
    chk("stray_res_ignored", {rnd_valid, busy, done, data_out}, 0);
    run(0, PT, KEY, 1, res, cyc);
    chk("after_rst_data_out", res, CT);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
